mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have the following ports: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high.
REQ-003 SHALL have these upstream ports:
- in_valid  input  1  op request
- in_ready  output  1  controller can accept
- in_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5-7 reserved
- in_src1  input  64  rs1 operand
- in_src2  input  64  rs2 operand
- flush  input  1  cancel the in-flight op
REQ-004 SHALL have these downstream ports:
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_result  output  64  final rd value
- err  output  1  sticky timeout flag
REQ-005 SHALL have these multiplier-side ports:
- mul_in_valid  output  1
- mul_flush  output  1
- mul_mulw  output  1
- mul_signed  output  2
- mul_multiplicand  output  64
- mul_multiplier  output  64
- mul_out_ready  input  1
- mul_out_valid  input  1
- mul_result_hi  input  64
- mul_result_lo  input  64

Function
REQ-006 SHALL implement a one-hot or encoded FSM with states IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-007 IDLE: in_ready=1; on in_valid it SHALL latch in_op, in_src1 and in_src2, then go to ISSUE (accept cycle T).
REQ-008 A reserved in_op SHALL be accepted and SHALL complete with out_result=0 via DONE at T+1, with no multiplier issue.
REQ-009 ISSUE: mul_in_valid SHALL equal mul_out_ready. When mul_out_ready=1, the controller SHALL go to WAIT; mul_in_valid is therefore a single-cycle pulse.
REQ-010 Operand mapping to the multiplier SHALL be:
- MUL/MULH: mul_signed=11
- MULHSU: mul_signed=10
- MULHU: mul_signed=00
- MULW: mul_signed=11, mul_mulw=1, both operands sign-extended from bit 31
- multiplicand=src1, multiplier=src2
- multiplier-side outputs SHALL be driven from the latched registers and SHALL hold stable outside ISSUE.
REQ-011 WAIT: on mul_out_valid the controller SHALL capture the selected result and go to DONE:
- MUL: lo
- MULH/MULHSU/MULHU: hi
- MULW: sign-extension of lo[31:0]
REQ-012 DONE: out_valid=1 and out_result SHALL hold stable until out_ready; on out_ready the controller SHALL go to IDLE. No new request is accepted in the same cycle.
REQ-013 Outside DONE, out_valid=0 and out_result=0.
REQ-014 A WAIT-cycle counter (7 bit) SHALL run as follows:
- cleared on entry to WAIT
- on reaching 64 without mul_out_valid: set err, pulse mul_flush, go to DRAIN.
REQ-015 flush in ISSUE, WAIT or DONE SHALL discard the op:
- ISSUE/WAIT: pulse mul_flush for one cycle and go to DRAIN
- DONE: go to IDLE
- flush in IDLE SHALL be ignored.
REQ-016 flush and mul_out_valid in the same WAIT cycle: flush SHALL win and the result SHALL be dropped.
REQ-017 DRAIN: the controller SHALL ignore mul_out_valid and return to IDLE on the first cycle with mul_out_ready=1.
REQ-018 Latency, from accept cycle T with an idle multiplier:
- mul_in_valid at T+1
- out_valid one cycle after mul_out_valid.
REQ-019 in_ready SHALL be 0 in every state except IDLE.

Reset
REQ-020 On reset the block SHALL enter IDLE with the following outputs:
- in_ready=1
- out_valid=0, out_result=0
- mul_in_valid=0, mul_flush=0
- err=0
- all operand and result registers 0
REQ-021 Reset mid-operation SHALL abandon the op without a mul_flush pulse; the multiplier is reset by the same reset.

Configuration
REQ-022 Macro MDU_RESULT_CACHE_EN:
- Defined: the block SHALL keep one entry {valid, op, src1, src2, result}, written on every DONE entry that came from WAIT.
- Hit: an IDLE accept whose op, src1 and src2 all match a valid entry SHALL go directly to DONE at T+1 with the cached result and no multiplier issue.
- The entry SHALL be invalidated only by reset.
- Undefined: the block SHALL contain no cache logic, and every op SHALL follow REQ-009..011.

Verification
REQ-023 MUL, src1=3, src2=-5 (0xFFFF_FFFF_FFFF_FFFB) -> mul_signed=11, a single mul_in_valid pulse, out_result=0xFFFF_FFFF_FFFF_FFF1.
REQ-024 MULHU, src1=src2=0xFFFF_FFFF_FFFF_FFFF -> out_result=0xFFFF_FFFF_FFFF_FFFE; MULHSU, src1=-1, src2=2 -> out_result=0xFFFF_FFFF_FFFF_FFFF.
REQ-025 MULW, src1=0x0000_0000_8000_0000, src2=2 -> mul_mulw=1, out_result=0x0000_0000_0000_0000; MULW, src1=0x4000_0000, src2=2 -> out_result=0xFFFF_FFFF_8000_0000.
REQ-026 flush 10 cycles into WAIT -> one-cycle mul_flush, no out_valid, then DRAIN->IDLE, and the next MUL 7x6 returns 42.
REQ-027 mul_out_valid held low for 64 WAIT cycles -> err=1 (sticky until reset), mul_flush pulse, return to IDLE.
REQ-028 With MDU_RESULT_CACHE_EN: MUL 7x6 issued twice -> the second op has no mul_in_valid, and out_valid at T+1 with 42; with out_ready=0 for 5 cycles, out_result holds 42.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - request, result and multiplier-side signal bundle for mdu_ctrl
// slave is the controller's view; master is the requester/consumer/multiplier side.
interface mdu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic        flush;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        err;

    logic        mul_in_valid;
    logic        mul_flush;
    logic        mul_mulw;
    logic [1:0]  mul_signed;
    logic [63:0] mul_multiplicand;
    logic [63:0] mul_multiplier;
    logic        mul_out_ready;
    logic        mul_out_valid;
    logic [63:0] mul_result_hi;
    logic [63:0] mul_result_lo;

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, flush, out_ready,
               mul_out_ready, mul_out_valid, mul_result_hi, mul_result_lo,
        output in_ready, out_valid, out_result, err,
               mul_in_valid, mul_flush, mul_mulw, mul_signed,
               mul_multiplicand, mul_multiplier
    );

    modport master (
        output in_valid, in_op, in_src1, in_src2, flush, out_ready,
               mul_out_ready, mul_out_valid, mul_result_hi, mul_result_lo,
        input  in_ready, out_valid, out_result, err,
               mul_in_valid, mul_flush, mul_mulw, mul_signed,
               mul_multiplicand, mul_multiplier
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply-unit controller sequencing one op through an external multiplier
// Optional single-entry result cache enabled by defining MDU_RESULT_CACHE_EN.
module mdu_ctrl (
    input  logic         clock,
    input  logic         reset,
    mdu_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [63:0] r_src1;
    logic [63:0] r_src2;
    logic [63:0] r_result;
    logic [6:0]  r_cnt;
    logic        r_err;

    logic        w_accept;
    logic        w_reserved;
    logic        w_cache_hit;
    logic [63:0] w_cache_result;
    logic        w_timeout;
    logic        w_capture;
    logic [63:0] w_sel_result;

    assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
    assign w_reserved = (bus.in_op > OP_MULW);
    // The 64th consecutive WAIT cycle without a result is the timeout cycle.
    assign w_timeout  = (r_state == S_WAIT) && !bus.flush && !bus.mul_out_valid && (r_cnt == 7'd63);
    assign w_capture  = (r_state == S_WAIT) && !bus.flush && bus.mul_out_valid;

    always_comb begin
        w_sel_result = bus.mul_result_hi;
        case (r_op)
            OP_MUL:  w_sel_result = bus.mul_result_lo;
            OP_MULW: w_sel_result = {{32{bus.mul_result_lo[31]}}, bus.mul_result_lo[31:0]};
            default: w_sel_result = bus.mul_result_hi;
        endcase
    end

`ifdef MDU_RESULT_CACHE_EN
    logic        r_c_valid;
    logic [2:0]  r_c_op;
    logic [63:0] r_c_src1;
    logic [63:0] r_c_src2;
    logic [63:0] r_c_result;

    assign w_cache_hit    = r_c_valid && (bus.in_op == r_c_op) &&
                            (bus.in_src1 == r_c_src1) && (bus.in_src2 == r_c_src2);
    assign w_cache_result = r_c_result;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_c_valid  <= 1'b0;
            r_c_op     <= 3'd0;
            r_c_src1   <= 64'd0;
            r_c_src2   <= 64'd0;
            r_c_result <= 64'd0;
        end else if (w_capture) begin
            r_c_valid  <= 1'b1;
            r_c_op     <= r_op;
            r_c_src1   <= r_src1;
            r_c_src2   <= r_src2;
            r_c_result <= w_sel_result;
        end
    end
`else
    assign w_cache_hit    = 1'b0;
    assign w_cache_result = 64'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_next = (w_reserved || w_cache_hit) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.flush) begin
                    w_next = S_DRAIN;
                end else if (bus.mul_out_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.flush || w_timeout) begin
                    w_next = S_DRAIN;
                end else if (bus.mul_out_valid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.flush || bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.mul_out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready     = (r_state == S_IDLE);
        bus.mul_in_valid = (r_state == S_ISSUE) && bus.mul_out_ready && !bus.flush;
        // Reset abandons the op silently; the multiplier sees the same reset.
        bus.mul_flush    = !reset && ((((r_state == S_ISSUE) || (r_state == S_WAIT)) && bus.flush) || w_timeout);
        bus.out_valid    = (r_state == S_DONE);
        bus.out_result   = (r_state == S_DONE) ? r_result : 64'd0;
        bus.err          = r_err;
    end

    always_comb begin
        bus.mul_mulw         = (r_op == OP_MULW);
        bus.mul_multiplicand = r_src1;
        bus.mul_multiplier   = r_src2;
        case (r_op)
            OP_MULHSU: bus.mul_signed = 2'b10;
            OP_MULHU:  bus.mul_signed = 2'b00;
            OP_MULW: begin
                bus.mul_signed       = 2'b11;
                bus.mul_multiplicand = {{32{r_src1[31]}}, r_src1[31:0]};
                bus.mul_multiplier   = {{32{r_src2[31]}}, r_src2[31:0]};
            end
            default:   bus.mul_signed = (r_op > OP_MULW) ? 2'b00 : 2'b11;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_op     <= 3'd0;
            r_src1   <= 64'd0;
            r_src2   <= 64'd0;
            r_result <= 64'd0;
            r_cnt    <= 7'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= bus.in_op;
                r_src1   <= bus.in_src1;
                r_src2   <= bus.in_src2;
                r_result <= w_cache_hit ? w_cache_result : 64'd0;
            end
            if (w_capture) begin
                r_result <= w_sel_result;
            end
            if (r_state != S_WAIT) begin
                r_cnt <= 7'd0;
            end else if (!bus.mul_out_valid) begin
                r_cnt <= r_cnt + 7'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl with a scripted multiplier
module tb_mdu_ctrl;
    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   issue_cnt;

    mdu_ctrl_if bus ();

    mdu_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && bus.mul_in_valid && bus.mul_out_ready) issue_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = s1;
        bus.in_src2  = s2;
        #1 check("in_ready_idle", bus.in_ready, 1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [63:0] hi, input logic [63:0] lo, input logic [63:0] res,
                          input logic [1:0] sig, input logic mulw,
                          input logic [63:0] mcand, input logic [63:0] mplier);
        int n0;
        n0 = issue_cnt;
        accept(op, s1, s2);
        check("issue_pulse", bus.mul_in_valid, 1);
        check("issue_in_ready", bus.in_ready, 0);
        check("mul_signed", bus.mul_signed, sig);
        check("mul_mulw", bus.mul_mulw, mulw);
        check("multiplicand", bus.mul_multiplicand, mcand);
        check("multiplier", bus.mul_multiplier, mplier);
        repeat (3) begin
            @(negedge clock);
            #1 check("wait_no_issue", bus.mul_in_valid, 0);
            check("wait_out_result", bus.out_result, 0);
        end
        @(negedge clock);
        bus.mul_result_hi = hi;
        bus.mul_result_lo = lo;
        bus.mul_out_valid = 1'b1;
        @(negedge clock);
        bus.mul_out_valid = 1'b0;
        #1 check("done_valid", bus.out_valid, 1);
        check("done_result", bus.out_result, res);
        check("issue_count", issue_cnt - n0, 1);
    endtask

    initial begin
        int n0;
        int n_to;
        checks = 0;
        errors = 0;
        issue_cnt = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_op = 3'd0;
        bus.in_src1 = 64'd0;
        bus.in_src2 = 64'd0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        bus.mul_out_ready = 1'b1;
        bus.mul_out_valid = 1'b0;
        bus.mul_result_hi = 64'd0;
        bus.mul_result_lo = 64'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_mul_in_valid", bus.mul_in_valid, 0);
        check("rst_mul_flush", bus.mul_flush, 0);
        check("rst_err", bus.err, 0);
        check("rst_multiplicand", bus.mul_multiplicand, 0);

        run_op(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1, 2'b11, 1'b0,
               64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
               64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run_op(3'd4, 64'h0000_0000_8000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_0000_0000, 64'd0, 2'b11, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd2);
        run_op(3'd4, 64'h0000_0000_4000_0000, 64'd2, 64'd0,
               64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 2'b11, 1'b1,
               64'h0000_0000_4000_0000, 64'd2);

        // Reserved op completes with zero without touching the multiplier.
        n0 = issue_cnt;
        accept(3'd5, 64'd1, 64'd2);
        check("rsv_valid", bus.out_valid, 1);
        check("rsv_result", bus.out_result, 0);
        check("rsv_no_issue", bus.mul_in_valid, 0);
        @(negedge clock);
        #1 check("rsv_back_idle", bus.in_ready, 1);
        check("rsv_issue_count", issue_cnt - n0, 0);

        @(negedge clock);
        bus.flush = 1'b1;
        #1 check("idle_flush_ignored", bus.mul_flush, 0);
        @(negedge clock);
        bus.flush = 1'b0;
        #1 check("idle_flush_in_ready", bus.in_ready, 1);

        // Flush ten cycles into WAIT, then hold DRAIN with a stray result.
        accept(3'd0, 64'd8, 64'd8);
        repeat (10) @(negedge clock);
        bus.flush = 1'b1;
        #1 check("wflush_pulse", bus.mul_flush, 1);
        @(negedge clock);
        bus.flush = 1'b0;
        bus.mul_out_ready = 1'b0;
        bus.mul_out_valid = 1'b1;
        bus.mul_result_lo = 64'd64;
        #1 check("wflush_one_cycle", bus.mul_flush, 0);
        check("wflush_no_out", bus.out_valid, 0);
        check("drain_in_ready", bus.in_ready, 0);
        @(negedge clock);
        bus.mul_out_ready = 1'b1;
        bus.mul_out_valid = 1'b0;
        #1 check("drain_holds", bus.in_ready, 0);
        check("drain_ignores_valid", bus.out_valid, 0);
        @(negedge clock);
        #1 check("drain_to_idle", bus.in_ready, 1);
        run_op(3'd0, 64'd7, 64'd6, 64'd0, 64'd42, 64'd42, 2'b11, 1'b0, 64'd7, 64'd6);

`ifdef MDU_RESULT_CACHE_EN
        n0 = issue_cnt;
        accept(3'd0, 64'd7, 64'd6);
        bus.out_ready = 1'b0;
        check("hit_valid", bus.out_valid, 1);
        check("hit_result", bus.out_result, 42);
        check("hit_no_issue", bus.mul_in_valid, 0);
        repeat (5) begin
            @(negedge clock);
            #1 check("hit_hold", bus.out_result, 42);
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        #1 check("hit_back_idle", bus.in_ready, 1);
        check("hit_issue_count", issue_cnt - n0, 0);
`endif

        // Flush and result in the same WAIT cycle: the result is dropped.
        accept(3'd0, 64'd9, 64'd9);
        repeat (2) @(negedge clock);
        bus.flush = 1'b1;
        bus.mul_out_valid = 1'b1;
        bus.mul_result_lo = 64'd81;
        #1 check("race_flush", bus.mul_flush, 1);
        @(negedge clock);
        bus.flush = 1'b0;
        bus.mul_out_valid = 1'b0;
        #1 check("race_dropped", bus.out_valid, 0);
        check("race_drain", bus.in_ready, 0);
        @(negedge clock);
        #1 check("race_idle", bus.in_ready, 1);

        accept(3'd0, 64'd5, 64'd5);
        @(negedge clock);
        bus.mul_result_hi = 64'd0;
        bus.mul_result_lo = 64'd25;
        bus.mul_out_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clock);
        bus.mul_out_valid = 1'b0;
        #1 check("dflush_result", bus.out_result, 25);
        bus.flush = 1'b1;
        #1 check("dflush_no_mul_flush", bus.mul_flush, 0);
        @(negedge clock);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        #1 check("dflush_no_out", bus.out_valid, 0);
        check("dflush_idle", bus.in_ready, 1);

        // Timeout: count WAIT cycles until the multiplier is flushed.
        accept(3'd0, 64'd11, 64'd11);
        n_to = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            #1;
            if (i == 1) check("to_err_before", bus.err, 0);
            if (bus.mul_flush) begin
                n_to = i;
                break;
            end
        end
        check("to_cycles", n_to, 64);
        @(negedge clock);
        #1 check("to_err_set", bus.err, 1);
        check("to_no_out", bus.out_valid, 0);
        check("to_flush_once", bus.mul_flush, 0);
        @(negedge clock);
        #1 check("to_idle", bus.in_ready, 1);
        run_op(3'd0, 64'd12, 64'd12, 64'd0, 64'd144, 64'd144, 2'b11, 1'b0, 64'd12, 64'd12);
        check("err_sticky", bus.err, 1);

        // Reset mid-op abandons without a flush pulse and clears err.
        accept(3'd0, 64'd13, 64'd13);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        bus.flush = 1'b1;
        #1 check("rst_mid_no_flush", bus.mul_flush, 0);
        @(negedge clock);
        reset = 1'b0;
        bus.flush = 1'b0;
        #1 check("rst_mid_idle", bus.in_ready, 1);
        check("rst_mid_err", bus.err, 0);
        check("rst_mid_out", bus.out_valid, 0);
        run_op(3'd0, 64'd2, 64'd3, 64'd0, 64'd6, 64'd6, 2'b11, 1'b0, 64'd2, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
